// File: rtl/rega_pkg.sv
// Shared types and limits for the irrigation timer controller.
// Holds the FSM state encoding and the BCD duration check.
package rega_pkg;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        LOAD,
        SETTLE,
        RUN,
        DONE,
        ABORT
    } stateT;

    localparam logic [3:0] UNIT_MAX = 4'd9;
    localparam logic [3:0] TENS_MAX = 4'd5;

    function automatic logic durValid(
        input logic [3:0] dm,
        input logic [3:0] um,
        input logic [3:0] ds,
        input logic [3:0] us
    );
        return (dm <= TENS_MAX) && (um <= UNIT_MAX) &&
               (ds <= TENS_MAX) && (us <= UNIT_MAX);
    endfunction

endpackage

// File: rtl/rega_sync_edge.sv
// Two-flop synchronizer for a raw asynchronous input.
// Provides the synchronized level and a one-cycle rising-edge pulse.
module rega_sync_edge (
    input  logic clock,
    input  logic reset_n,
    input  logic din,
    output logic level,
    output logic rise
);

    logic meta;
    logic syncQ;
    logic prevQ;

    // metastability stage, stable stage, and a delayed copy for the edge
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta  <= 1'b0;
            syncQ <= 1'b0;
            prevQ <= 1'b0;
        end else begin
            meta  <= din;
            syncQ <= meta;
            prevQ <= syncQ;
        end
    end

    assign level = syncQ;
    assign rise  = syncQ & ~prevQ;

endmodule

// File: rtl/rega_timer_ctrl.sv
// Upstream controller for the irrigation countdown timer.
// Loads the duration, runs the count clock and drives the valve.
module rega_timer_ctrl
    import rega_pkg::*;
#(
    parameter int TICK_DIV    = 50000000,
    parameter int SCAN_DIV    = 50000,
    parameter int LOAD_CYCLES = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic       abort,
    input  logic       stop,
    input  logic [3:0] dur_dm,
    input  logic [3:0] dur_um,
    input  logic [3:0] dur_ds,
    input  logic [3:0] dur_us,
    output logic       new_clock,
    output logic [1:0] seletor,
    output logic [3:0] preset_dm,
    output logic [3:0] preset_um,
    output logic [3:0] preset_ds,
    output logic [3:0] preset_us,
    output logic [3:0] clear_dm,
    output logic [3:0] clear_um,
    output logic [3:0] clear_ds,
    output logic [3:0] clear_us,
    output logic       valve,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CMAX = (LOAD_CYCLES > 3) ? LOAD_CYCLES : 3;
    localparam int CW = $clog2(CMAX + 1);

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    // new_clock falls on the edge where the count becomes TICK_DIV/2-1
    localparam logic [TW-1:0] TICK_FALL = TW'(TICK_DIV / 2 - 2);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] LOAD_LAST = CW'(LOAD_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(2);

    stateT state;
    logic [CW-1:0] cnt;
    logic [TW-1:0] tickCnt;
    logic [SW-1:0] scanCnt;
    logic [3:0] durDm, durUm, durDs, durUs;

    logic startPulse;
    logic abortPulse;
    logic stopLvl;
    logic startLvlUnused;
    logic abortLvlUnused;
    logic stopRiseUnused;

    rega_sync_edge uStartSync (
        .clock  (clock),
        .reset_n(reset_n),
        .din    (start),
        .level  (startLvlUnused),
        .rise   (startPulse)
    );

    rega_sync_edge uAbortSync (
        .clock  (clock),
        .reset_n(reset_n),
        .din    (abort),
        .level  (abortLvlUnused),
        .rise   (abortPulse)
    );

    rega_sync_edge uStopSync (
        .clock  (clock),
        .reset_n(reset_n),
        .din    (stop),
        .level  (stopLvl),
        .rise   (stopRiseUnused)
    );

    // free-running display scan, independent of the FSM
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scanCnt <= '0;
            seletor <= 2'd0;
        end else if (scanCnt == SCAN_LAST) begin
            scanCnt <= '0;
            seletor <= seletor + 2'd1;
        end else begin
            scanCnt <= scanCnt + 1'b1;
        end
    end

    // controller FSM with all timer-facing outputs registered
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= INIT;
            cnt       <= '0;
            tickCnt   <= '0;
            new_clock <= 1'b0;
            durDm     <= 4'h0;
            durUm     <= 4'h0;
            durDs     <= 4'h0;
            durUs     <= 4'h0;
            preset_dm <= 4'hF;
            preset_um <= 4'hF;
            preset_ds <= 4'hF;
            preset_us <= 4'hF;
            clear_dm  <= 4'h0;
            clear_um  <= 4'h0;
            clear_ds  <= 4'h0;
            clear_us  <= 4'h0;
            valve     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abortPulse && busy) begin
                state     <= ABORT;
                cnt       <= '0;
                tickCnt   <= '0;
                new_clock <= 1'b0;
                valve     <= 1'b0;
                busy      <= 1'b0;
                preset_dm <= 4'hF;
                preset_um <= 4'hF;
                preset_ds <= 4'hF;
                preset_us <= 4'hF;
                clear_dm  <= 4'h0;
                clear_um  <= 4'h0;
                clear_ds  <= 4'h0;
                clear_us  <= 4'h0;
            end else begin
                unique case (state)
                    INIT, ABORT: begin
                        if (cnt == LOAD_LAST) begin
                            state    <= IDLE;
                            cnt      <= '0;
                            clear_dm <= 4'hF;
                            clear_um <= 4'hF;
                            clear_ds <= 4'hF;
                            clear_us <= 4'hF;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    IDLE: begin
                        if (startPulse) begin
                            if (durValid(dur_dm, dur_um, dur_ds, dur_us)) begin
                                state     <= LOAD;
                                cnt       <= '0;
                                err       <= 1'b0;
                                busy      <= 1'b1;
                                durDm     <= dur_dm;
                                durUm     <= dur_um;
                                durDs     <= dur_ds;
                                durUs     <= dur_us;
                                preset_dm <= ~dur_dm;
                                preset_um <= ~dur_um;
                                preset_ds <= ~dur_ds;
                                preset_us <= ~dur_us;
                                clear_dm  <= dur_dm;
                                clear_um  <= dur_um;
                                clear_ds  <= dur_ds;
                                clear_us  <= dur_us;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                    LOAD: begin
                        if (cnt == LOAD_LAST) begin
                            state     <= SETTLE;
                            cnt       <= '0;
                            preset_dm <= 4'hF;
                            preset_um <= 4'hF;
                            preset_ds <= 4'hF;
                            preset_us <= 4'hF;
                            clear_dm  <= 4'hF;
                            clear_um  <= 4'hF;
                            clear_ds  <= 4'hF;
                            clear_us  <= 4'hF;
                        end else begin
                            cnt       <= cnt + 1'b1;
                            preset_dm <= ~durDm;
                            preset_um <= ~durUm;
                            preset_ds <= ~durDs;
                            preset_us <= ~durUs;
                            clear_dm  <= durDm;
                            clear_um  <= durUm;
                            clear_ds  <= durDs;
                            clear_us  <= durUs;
                        end
                    end
                    SETTLE: begin
                        if (cnt == SETTLE_LAST) begin
                            cnt <= '0;
                            if (stopLvl) begin
                                state <= DONE;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                            end else begin
                                state   <= RUN;
                                valve   <= 1'b1;
                                tickCnt <= '0;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    RUN: begin
                        if (stopLvl) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            valve     <= 1'b0;
                            new_clock <= 1'b0;
                            tickCnt   <= '0;
                        end else if (tickCnt == TICK_LAST) begin
                            tickCnt   <= '0;
                            new_clock <= 1'b1;
                        end else begin
                            tickCnt <= tickCnt + 1'b1;
                            if (tickCnt == TICK_FALL) begin
                                new_clock <= 1'b0;
                            end
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= INIT;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rega_timer_ctrl.sv
// Directed bench for rega_timer_ctrl with a BCD countdown timer model.
// Table of start vectors plus hand-written multi-cycle sequences.
module tb_rega_timer_ctrl;

    localparam int TICK_DIV    = 8;
    localparam int SCAN_DIV    = 4;
    localparam int LOAD_CYCLES = 2;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic stop;
    logic [3:0] dur_dm = 4'h0;
    logic [3:0] dur_um = 4'h0;
    logic [3:0] dur_ds = 4'h0;
    logic [3:0] dur_us = 4'h0;
    logic new_clock;
    logic [1:0] seletor;
    logic [3:0] preset_dm, preset_um, preset_ds, preset_us;
    logic [3:0] clear_dm, clear_um, clear_ds, clear_us;
    logic valve, busy, done, err;

    always #5 clock = ~clock;

    rega_timer_ctrl #(
        .TICK_DIV   (TICK_DIV),
        .SCAN_DIV   (SCAN_DIV),
        .LOAD_CYCLES(LOAD_CYCLES)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (start),
        .abort    (abort),
        .stop     (stop),
        .dur_dm   (dur_dm),
        .dur_um   (dur_um),
        .dur_ds   (dur_ds),
        .dur_us   (dur_us),
        .new_clock(new_clock),
        .seletor  (seletor),
        .preset_dm(preset_dm),
        .preset_um(preset_um),
        .preset_ds(preset_ds),
        .preset_us(preset_us),
        .clear_dm (clear_dm),
        .clear_um (clear_um),
        .clear_ds (clear_ds),
        .clear_us (clear_us),
        .valve    (valve),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    logic [15:0] pre;
    logic [15:0] clr;
    assign pre = {preset_dm, preset_um, preset_ds, preset_us};
    assign clr = {clear_dm, clear_um, clear_ds, clear_us};

    // timer model: mm:ss BCD digits, async-style preset/clear, stop at zero
    logic [15:0] tm = 16'h1234;
    logic ncQ = 1'b0;
    assign stop = (tm == 16'h0000);

    function automatic logic [15:0] decBcd(input logic [15:0] t);
        logic [3:0] dm, um, ds, us;
        {dm, um, ds, us} = t;
        if (t == 16'h0000) return t;
        if (us != 0) us = us - 1;
        else begin
            us = 9;
            if (ds != 0) ds = ds - 1;
            else begin
                ds = 5;
                if (um != 0) um = um - 1;
                else begin
                    um = 9;
                    dm = dm - 1;
                end
            end
        end
        return {dm, um, ds, us};
    endfunction

    always @(posedge clock) begin
        logic [15:0] v;
        v = (new_clock && !ncQ) ? decBcd(tm) : tm;
        ncQ <= new_clock;
        tm  <= (v | ~pre) & clr;
    end

    int nChecks = 0;
    int nPass = 0;

    task automatic chk(input string nm, input int act, input int exp);
        nChecks++;
        if (act !== exp)
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        else
            nPass++;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic pressStart();
        start = 1'b1;
        cyc(3);
        start = 1'b0;
    endtask

    int wRises, wMinGap, wMaxGap, wDones, wValveCyc, wClr0;
    int wValveRise, wValveFall, wFirstRise, wStopRise;

    task automatic watch(input int n);
        int lastRise;
        logic pNc, pV, pS;
        wRises = 0; wMinGap = 1000; wMaxGap = 0; wDones = 0;
        wValveCyc = 0; wClr0 = 0; wValveRise = -1; wValveFall = -1;
        wFirstRise = -1; wStopRise = -1; lastRise = -1;
        pNc = new_clock; pV = valve; pS = stop;
        for (int i = 1; i <= n; i++) begin
            cyc(1);
            if (new_clock && !pNc) begin
                wRises++;
                if (wFirstRise < 0) wFirstRise = i;
                if (lastRise >= 0) begin
                    if (i - lastRise < wMinGap) wMinGap = i - lastRise;
                    if (i - lastRise > wMaxGap) wMaxGap = i - lastRise;
                end
                lastRise = i;
            end
            if (done) wDones++;
            if (valve) wValveCyc++;
            if (clr == 16'h0000) wClr0++;
            if (valve && !pV) wValveRise = i;
            if (!valve && pV) wValveFall = i;
            if (stop && !pS) wStopRise = i;
            pNc = new_clock; pV = valve; pS = stop;
        end
    endtask

    typedef struct {
        logic [15:0] dur;
        logic        expErr;
        logic [15:0] expClr;
        logic [15:0] expPre;
    } vecT;

    vecT tbl[8];

    initial begin
        int r;
        logic p;

        tbl[0] = '{16'h0003, 1'b0, 16'h0003, 16'hFFFC};
        tbl[1] = '{16'h0070, 1'b1, 16'hFFFF, 16'hFFFF};
        tbl[2] = '{16'h5959, 1'b0, 16'h5959, 16'hA6A6};
        tbl[3] = '{16'h6000, 1'b1, 16'hFFFF, 16'hFFFF};
        tbl[4] = '{16'h1234, 1'b0, 16'h1234, 16'hEDCB};
        tbl[5] = '{16'h0A00, 1'b1, 16'hFFFF, 16'hFFFF};
        tbl[6] = '{16'h000A, 1'b1, 16'hFFFF, 16'hFFFF};
        tbl[7] = '{16'h0409, 1'b0, 16'h0409, 16'hFBF6};

        // reset values
        cyc(2);
        chk("rst_clr", int'(clr), 16'h0000);
        chk("rst_pre", int'(pre), 16'hFFFF);
        chk("rst_outs", int'({valve, busy, done, err, new_clock}), 0);
        chk("rst_sel", int'(seletor), 0);
        reset_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            cyc(1);
            if (k == 1) chk("init_clr0", int'(clr), 16'h0000);
            if (k == 2) chk("init_clrF", int'(clr), 16'hFFFF);
            if (k % 4 == 0 || k == 3)
                chk($sformatf("sel_k%0d", k), int'(seletor), (k / 4) % 4);
        end
        chk("init_tm", int'(tm), 0);

        // table: validity and LOAD line mapping
        foreach (tbl[i]) begin
            {dur_dm, dur_um, dur_ds, dur_us} = tbl[i].dur;
            pressStart();
            chk($sformatf("tbl%0d_busy", i), int'(busy), int'(!tbl[i].expErr));
            chk($sformatf("tbl%0d_clr", i), int'(clr), int'(tbl[i].expClr));
            chk($sformatf("tbl%0d_pre", i), int'(pre), int'(tbl[i].expPre));
            chk($sformatf("tbl%0d_err", i), int'(err), int'(tbl[i].expErr));
            abort = 1'b1;
            cyc(3);
            abort = 1'b0;
            cyc(6);
            chk($sformatf("tbl%0d_idle", i), int'(busy), 0);
        end

        // 00:03 full cycle, duration change during LOAD ignored
        {dur_dm, dur_um, dur_ds, dur_us} = 16'h0003;
        pressStart();
        chk("d3_load_clr", int'(clear_us), 4'h3);
        chk("d3_load_pre", int'(preset_us), 4'hC);
        dur_us = 4'h9;
        cyc(1);
        chk("d3_load_hold", int'(clear_us), 4'h3);
        cyc(1);
        chk("d3_settle_clr", int'(clr), 16'hFFFF);
        watch(60);
        chk("d3_rises", wRises, 3);
        chk("d3_gapmin", wMinGap, TICK_DIV);
        chk("d3_gapmax", wMaxGap, TICK_DIV);
        chk("d3_first", wFirstRise - wValveRise, TICK_DIV);
        chk("d3_stop_lat", wValveFall - wStopRise, 3);
        chk("d3_done", wDones, 1);
        chk("d3_end", int'({valve, busy, new_clock}), 0);
        chk("d3_tm", int'(tm), 0);

        // 00:00 zero duration
        {dur_dm, dur_um, dur_ds, dur_us} = 16'h0000;
        pressStart();
        watch(20);
        chk("d0_rises", wRises, 0);
        chk("d0_valve", wValveCyc, 0);
        chk("d0_done", wDones, 1);
        chk("d0_busy", int'(busy), 0);

        // invalid 00:70 then valid start clears err
        {dur_dm, dur_um, dur_ds, dur_us} = 16'h0070;
        pressStart();
        cyc(4);
        chk("inv_err", int'(err), 1);
        chk("inv_busy", int'(busy), 0);
        {dur_dm, dur_um, dur_ds, dur_us} = 16'h0001;
        pressStart();
        chk("val_err", int'(err), 0);
        chk("val_busy", int'(busy), 1);
        watch(40);
        chk("d1_rises", wRises, 1);
        chk("d1_done", wDones, 1);

        // 01:00 abort after 5 ticks
        {dur_dm, dur_um, dur_ds, dur_us} = 16'h0100;
        pressStart();
        r = 0;
        p = new_clock;
        for (int i = 0; i < 120 && r < 5; i++) begin
            cyc(1);
            if (new_clock && !p) r++;
            p = new_clock;
        end
        chk("ab_rises", r, 5);
        cyc(1);
        chk("ab_tm", int'(tm), 16'h0055);
        abort = 1'b1;
        cyc(2);
        abort = 1'b0;
        watch(10);
        chk("ab_clr0", wClr0, LOAD_CYCLES);
        chk("ab_vfall", wValveFall, 1);
        chk("ab_valve", wValveCyc, 0);
        chk("ab_done", wDones, 0);
        chk("ab_rises2", wRises, 0);
        chk("ab_idle", int'({busy, valve}), 0);
        chk("ab_clrF", int'(clr), 16'hFFFF);
        chk("ab_tm0", int'(tm), 0);

        // async reset mid-RUN while new_clock is high
        {dur_dm, dur_um, dur_ds, dur_us} = 16'h0009;
        pressStart();
        r = 0;
        p = new_clock;
        for (int i = 0; i < 120 && r < 2; i++) begin
            cyc(1);
            if (new_clock && !p) r++;
            p = new_clock;
        end
        chk("mr_rises", r, 2);
        chk("mr_nc_hi", int'(new_clock & valve), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mr_valve", int'(valve), 0);
        chk("mr_nc", int'(new_clock), 0);
        chk("mr_clr", int'(clr), 16'h0000);
        cyc(2);
        reset_n = 1'b1;
        cyc(1);
        chk("mr_init_clr0", int'(clr), 16'h0000);
        cyc(1);
        chk("mr_init_clrF", int'(clr), 16'hFFFF);
        chk("mr_tm", int'(tm), 0);
        chk("mr_busy", int'(busy), 0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
